// File: rtl/round_robin_arbiter.sv
// ----------------------------------------------------------------------------
// round_robin_arbiter
//
// Purpose:
//    Grants one of NUM_INPUTS requesters at a time using a rotating priority
//    pointer. A grant is held until the holder signals end-of-use
//    (in_release) or drops its request line. After every release the pointer
//    moves to the requester just past the one that was served, so every
//    continuously requesting requester is served within NUM_INPUTS-1 grants.
//
// Optional feature (macro ARB_HOLD_LIMIT_EN):
//    When defined, a 16-bit hold counter forces a release after MAX_HOLD
//    cycles in GRANTED and pulses out_timeout for one cycle. When undefined
//    there is no counter, out_timeout is tied low and holds are unlimited.
//
// Parameters:
//    NUM_INPUTS  number of requesters (2..32)
//    MAX_HOLD    forced-release limit in cycles (2..65535), limit build only
//
// Ports:
//    clk          input   1           single clock, rising edge
//    reset_n      input   1           asynchronous active-low reset
//    in_requests  input   NUM_INPUTS  per-requester request level
//    in_release   input   1           holder's end-of-use pulse (tail flit)
//    out_grant    output  NUM_INPUTS  one-hot grant, registered
//    out_index    output  NUM_BITS    binary index of granted requester
//    out_valid    output  1           high while a grant is held
//    out_timeout  output  1           one-cycle pulse on forced release
// ----------------------------------------------------------------------------
module round_robin_arbiter #(
   parameter int NUM_INPUTS = 4,
   parameter int MAX_HOLD   = 16
) (
   input  logic                          clk,
   input  logic                          reset_n,
   input  logic [NUM_INPUTS-1:0]         in_requests,
   input  logic                          in_release,
   output logic [NUM_INPUTS-1:0]         out_grant,
   output logic [$clog2(NUM_INPUTS)-1:0] out_index,
   output logic                          out_valid,
   output logic                          out_timeout
);

   localparam int NUM_BITS = $clog2(NUM_INPUTS);

   typedef enum logic {
      IDLE,
      GRANTED
   } state_t;

   // Reject parameter values outside the supported ranges at elaboration.
   if (NUM_INPUTS < 2 || NUM_INPUTS > 32 || MAX_HOLD < 2 || MAX_HOLD > 65535) begin : g_badParams
      $error("round_robin_arbiter: NUM_INPUTS or MAX_HOLD out of range");
   end

   state_t                r_state;
   logic [NUM_BITS-1:0]   r_ptr;
   logic [NUM_INPUTS-1:0] r_grant;
   logic [NUM_BITS-1:0]   r_index;
   logic                  r_valid;

   logic                  w_found;
   logic [NUM_BITS-1:0]   w_nextIdx;
   logic                  w_release;
   logic [NUM_BITS-1:0]   w_ptrNext;

   // Rotating priority search: first scan from the pointer up to the top
   // requester, then wrap and scan from requester 0 up to just below the
   // pointer. Two passes avoid modulo arithmetic for non-power-of-two sizes.
   always_comb begin
      w_found   = 1'b0;
      w_nextIdx = '0;
      for (int j = 0; j < NUM_INPUTS; j++) begin
         if (!w_found && j >= int'(r_ptr) && in_requests[j]) begin
            w_found   = 1'b1;
            w_nextIdx = NUM_BITS'(j);
         end
      end
      for (int j = 0; j < NUM_INPUTS; j++) begin
         if (!w_found && j < int'(r_ptr) && in_requests[j]) begin
            w_found   = 1'b1;
            w_nextIdx = NUM_BITS'(j);
         end
      end
   end

   // A release is either the explicit tail pulse or the holder dropping its
   // request; both together still count as a single release.
   always_comb begin
      w_release = in_release || !in_requests[r_index];
      w_ptrNext = (r_index == NUM_BITS'(NUM_INPUTS - 1)) ? '0 : r_index + NUM_BITS'(1);
   end

`ifdef ARB_HOLD_LIMIT_EN
   localparam logic [15:0] HOLD_LAST = 16'(MAX_HOLD - 1);

   logic [15:0] r_holdCnt;
   logic        r_timeout;

   // Arbiter FSM with hold limit. A natural release takes priority over the
   // limit, so the timeout pulse only fires when the holder overstays.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state   <= IDLE;
         r_ptr     <= '0;
         r_grant   <= '0;
         r_index   <= '0;
         r_valid   <= 1'b0;
         r_holdCnt <= '0;
         r_timeout <= 1'b0;
      end else begin
         r_timeout <= 1'b0;
         case (r_state)
            IDLE: begin
               if (w_found) begin
                  r_state   <= GRANTED;
                  r_grant   <= NUM_INPUTS'(1) << w_nextIdx;
                  r_index   <= w_nextIdx;
                  r_valid   <= 1'b1;
                  r_holdCnt <= '0;
               end
            end
            GRANTED: begin
               if (w_release || r_holdCnt == HOLD_LAST) begin
                  r_state   <= IDLE;
                  r_grant   <= '0;
                  r_index   <= '0;
                  r_valid   <= 1'b0;
                  r_ptr     <= w_ptrNext;
                  r_holdCnt <= '0;
                  r_timeout <= !w_release;
               end else begin
                  r_holdCnt <= r_holdCnt + 16'd1;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign out_timeout = r_timeout;
`else
   // Arbiter FSM without hold limit: a grant lasts until the holder releases.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= IDLE;
         r_ptr   <= '0;
         r_grant <= '0;
         r_index <= '0;
         r_valid <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_found) begin
                  r_state <= GRANTED;
                  r_grant <= NUM_INPUTS'(1) << w_nextIdx;
                  r_index <= w_nextIdx;
                  r_valid <= 1'b1;
               end
            end
            GRANTED: begin
               if (w_release) begin
                  r_state <= IDLE;
                  r_grant <= '0;
                  r_index <= '0;
                  r_valid <= 1'b0;
                  r_ptr   <= w_ptrNext;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign out_timeout = 1'b0;
`endif

   assign out_grant = r_grant;
   assign out_index = r_index;
   assign out_valid = r_valid;

endmodule

// File: tb/tb_round_robin_arbiter.sv
// ----------------------------------------------------------------------------
// tb_round_robin_arbiter
//
// Directed bench for round_robin_arbiter with NUM_INPUTS=4, MAX_HOLD=4.
// The stimulus process pushes the index it expects to be granted next into a
// scoreboard queue; a monitor pops and compares every time a new grant
// appears. Cycle-exact state (bubbles, holds, reset, timeout) is checked
// directly after each driven edge. Timeout expectations follow whether
// ARB_HOLD_LIMIT_EN is defined for the build.
// ----------------------------------------------------------------------------
module tb_round_robin_arbiter;

   logic       clk;
   logic       reset_n;
   logic [3:0] in_requests;
   logic       in_release;
   logic [3:0] out_grant;
   logic [1:0] out_index;
   logic       out_valid;
   logic       out_timeout;

   int assertCount = 0;
   int failCount   = 0;

   logic [1:0] sbQueue[$];

   round_robin_arbiter #(
      .NUM_INPUTS(4),
      .MAX_HOLD  (4)
   ) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .in_requests(in_requests),
      .in_release (in_release),
      .out_grant  (out_grant),
      .out_index  (out_index),
      .out_valid  (out_valid),
      .out_timeout(out_timeout)
   );

   // Free-running 10-unit clock, rising edges at 5, 15, 25, ...
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Single comparison with a failure report.
   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      assertCount++;
      if (actual !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   // Checks the full registered output set against hand-computed values.
   task automatic expectState(input string tag, input logic valid, input logic [1:0] idx, input logic timeout);
      logic [3:0] one;
      one = 4'b0001;
      checkOutput({tag, " valid"}, 32'(out_valid), 32'(valid));
      checkOutput({tag, " index"}, 32'(out_index), 32'(idx));
      checkOutput({tag, " grant"}, 32'(out_grant), valid ? 32'(one << idx) : 32'd0);
      checkOutput({tag, " timeout"}, 32'(out_timeout), 32'(timeout));
   endtask

   // Drives one cycle of inputs, lets one rising edge pass, then returns
   // 1 unit after that edge with the release pulse already withdrawn.
   task automatic applyStimulus(input logic [3:0] req, input logic rel);
      in_requests = req;
      in_release  = rel;
      @(posedge clk);
      #1;
      in_release  = 1'b0;
   endtask

   // Scoreboard monitor: a rising out_valid marks a new grant.
   initial begin
      logic       prevValid;
      logic [1:0] expIdx;
      logic [3:0] one;
      prevValid = 1'b0;
      one       = 4'b0001;
      forever begin
         @(negedge clk);
         if (out_valid && !prevValid) begin
            if (sbQueue.size() == 0) begin
               assertCount++;
               failCount++;
               $display("[TB] FAIL sb unexpected grant: got index %0d, expected none", out_index);
            end else begin
               expIdx = sbQueue.pop_front();
               checkOutput("sb index", 32'(out_index), 32'(expIdx));
               checkOutput("sb grant", 32'(out_grant), 32'(one << expIdx));
            end
         end
         prevValid = out_valid;
      end
   end

   initial begin
      reset_n     = 1'b1;
      in_requests = 4'b0000;
      in_release  = 1'b0;
      #1 reset_n = 1'b0;
      #11;
      expectState("reset", 1'b0, 2'd0, 1'b0);
      @(negedge clk);
      reset_n = 1'b1;

      // Pointer starts at 0: 0110 selects requester 1, then 2, then wraps to 1.
      sbQueue.push_back(2'd1);
      applyStimulus(4'b0110, 1'b0);
      expectState("first grant", 1'b1, 2'd1, 1'b0);
      sbQueue.push_back(2'd2);
      applyStimulus(4'b0110, 1'b1);
      expectState("bubble a", 1'b0, 2'd0, 1'b0);
      applyStimulus(4'b0110, 1'b0);
      expectState("grant idx2", 1'b1, 2'd2, 1'b0);
      sbQueue.push_back(2'd1);
      applyStimulus(4'b0110, 1'b1);
      expectState("bubble b", 1'b0, 2'd0, 1'b0);
      applyStimulus(4'b0110, 1'b0);
      expectState("wrap grant", 1'b1, 2'd1, 1'b0);

      // Holder 1 drops its line; pointer 2 finds nothing until wrap to 0.
      sbQueue.push_back(2'd0);
      applyStimulus(4'b0001, 1'b0);
      expectState("drop release", 1'b0, 2'd0, 1'b0);
      applyStimulus(4'b0001, 1'b0);
      expectState("grant idx0", 1'b1, 2'd0, 1'b0);

      // No preemption while everyone requests.
      applyStimulus(4'b1111, 1'b0);
      expectState("no preempt a", 1'b1, 2'd0, 1'b0);
      applyStimulus(4'b1111, 1'b0);
      expectState("no preempt b", 1'b1, 2'd0, 1'b0);
      sbQueue.push_back(2'd1);
      applyStimulus(4'b1110, 1'b0);
      expectState("holder drop", 1'b0, 2'd0, 1'b0);
      applyStimulus(4'b1110, 1'b0);
      expectState("grant after drop", 1'b1, 2'd1, 1'b0);

      // Asynchronous reset mid-grant, between clock edges.
      @(negedge clk);
      #2 reset_n = 1'b0;
      #1;
      expectState("async reset", 1'b0, 2'd0, 1'b0);
      @(posedge clk);
      #1;
      expectState("reset held", 1'b0, 2'd0, 1'b0);
      sbQueue.push_back(2'd3);
      reset_n = 1'b1;
      applyStimulus(4'b1000, 1'b0);
      expectState("post reset grant", 1'b1, 2'd3, 1'b0);

      // Release from 3 wraps the pointer to 0; release in IDLE is ignored.
      applyStimulus(4'b0000, 1'b0);
      expectState("release idx3", 1'b0, 2'd0, 1'b0);
      applyStimulus(4'b0000, 1'b1);
      expectState("release in idle", 1'b0, 2'd0, 1'b0);
      applyStimulus(4'b0000, 1'b0);
      expectState("idle", 1'b0, 2'd0, 1'b0);

      // Long hold on requester 2; requester 1 waits behind it.
      sbQueue.push_back(2'd2);
      applyStimulus(4'b0100, 1'b0);
      expectState("hold grant", 1'b1, 2'd2, 1'b0);
`ifdef ARB_HOLD_LIMIT_EN
      for (int k = 1; k <= 3; k++) begin
         applyStimulus(4'b0110, 1'b0);
         expectState("hold limited", 1'b1, 2'd2, 1'b0);
      end
      applyStimulus(4'b0110, 1'b0);
      expectState("forced release", 1'b0, 2'd0, 1'b1);
      sbQueue.push_back(2'd1);
      applyStimulus(4'b0110, 1'b0);
      expectState("after timeout", 1'b1, 2'd1, 1'b0);
`else
      for (int k = 1; k <= 8; k++) begin
         applyStimulus(4'b0110, 1'b0);
         expectState("hold unlimited", 1'b1, 2'd2, 1'b0);
      end
      sbQueue.push_back(2'd1);
      applyStimulus(4'b0110, 1'b1);
      expectState("late release", 1'b0, 2'd0, 1'b0);
      applyStimulus(4'b0110, 1'b0);
      expectState("after late release", 1'b1, 2'd1, 1'b0);
`endif

      applyStimulus(4'b0000, 1'b0);
      expectState("final idle", 1'b0, 2'd0, 1'b0);
      @(negedge clk);
      @(negedge clk);
      checkOutput("sb drained", 32'(sbQueue.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
